// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing for the text-rendering path.
// Divides clk into a pixel tick and runs the horizontal and vertical raster counters.
// Every output is registered and decoded from the next counter values, so the syncs,
// video_on and the coordinates all change on the same posedge.
//   clk, rst_n   system clock, asynchronous active-low reset
//   pix_en       one-clk pulse in the cycle where the divider sits at CLK_DIV-1
//   hsync/vsync  sync outputs, active level set by SYNC_POL
//   video_on     current (horzCoord, vertCoord) lies in the visible area
//   horzCoord    pixel column, 0..H_TOTAL-1
//   vertCoord    line, 0..V_TOTAL-1
//   line_start   one-clk pulse when horzCoord wraps to 0
//   frame_start  one-clk pulse when both coordinates wrap to (0,0)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [31:0] horzCoord,
  output logic [31:0] vertCoord,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [31:0]      h_next;
  logic [31:0]      v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             pix_en_next;
  logic             hs_next;
  logic             vs_next;
  logic             von_next;

  // Next-state computation; pix_en (registered) marks the edge on which the counters advance.
  always_comb begin
    div_next    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    pix_en_next = (div_next == DIV_LAST);
    h_wrap      = pix_en && (horzCoord == 32'(H_TOTAL - 1));
    v_wrap      = h_wrap && (vertCoord == 32'(V_TOTAL - 1));
    h_next      = horzCoord;
    v_next      = vertCoord;
    if (pix_en) begin
      h_next = h_wrap ? '0 : horzCoord + 32'd1;
    end
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vertCoord + 32'd1;
    end
    hs_next  = (h_next >= 32'(HS_START)) && (h_next < 32'(HS_END));
    vs_next  = (v_next >= 32'(VS_START)) && (v_next < 32'(VS_END));
    von_next = (h_next < 32'(H_VISIBLE)) && (v_next < 32'(V_VISIBLE));
  end

  // State and output registers; decoding from next values keeps syncs aligned to coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      horzCoord   <= '0;
      vertCoord   <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_next;
      pix_en      <= pix_en_next;
      horzCoord   <= h_next;
      vertCoord   <= v_next;
      hsync       <= hs_next ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_next ? SYNC_POL : ~SYNC_POL;
      video_on    <= von_next;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule
